cpu_init_loader: RTL
====================

# cpu_init_loader

Boot-time writer for the pipelined CPU's table-initialisation ports. It accepts a byte stream over a valid/ready handshake and parses it into records. Each record is turned into a write on the BTB, BHT or register-file init port. A start record releases the CPU by dropping `rst_switch` and raising `start_switch`. It sits between a host byte source (UART receiver or test harness) and the CPU top.

## Interface
Parameters:
- `STRETCH`, default 2: cycles each write's addr/data/we are held stable. Must be ≥2 so the CPU's half-rate sampler sees every write.
- `IDLE_TIMEOUT`, default 1_000_000: idle cycles allowed inside a partial record before it is aborted.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input byte valid.
- `s_data`  in  8  input byte.
- `s_ready`  out  1  loader accepts a byte this cycle.
- `btb_addr`  out  8  BTB entry index.
- `btb_init`  out  40  BTB entry data.
- `btb_we`  out  1  BTB write strobe.
- `bht_addr`  out  8  BHT entry index.
- `bht_init`  out  2  BHT 2-bit counter value.
- `bht_we`  out  1  BHT write strobe.
- `reg_addr`  out  5  register index.
- `reg_init`  out  32  register value.
- `reg_we`  out  1  register write strobe.
- `rst_switch`  out  1  high while loading; holds the CPU tables in init mode.
- `start_switch`  out  1  high once the start record is seen.
- `busy`  out  1  a record is in progress (ADDR, DATA or WRITE).
- `err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- Byte transfer: a byte is taken when `s_valid && s_ready` at a rising `clk`.
- `s_ready` is 1 in HDR, ADDR and DATA. It is 0 in WRITE, RUN and while `rst` is high.
- Record header codes:
  - 0x00: NOP. Consumed; no further bytes.
  - 0x01: BTB. Followed by 1 address byte and 5 data bytes.
  - 0x02: BHT. Followed by 1 address byte and 1 data byte; only bits [1:0] are used.
  - 0x03: REG. Followed by 1 address byte (only bits [4:0] used) and 4 data bytes.
  - 0xFF: START.
- Data bytes are big-endian: the first byte received is the MSB.
- States:
  - HDR: on a valid header go to ADDR (or handle NOP/START). On an unknown header set `err`, drop the byte and stay in HDR.
  - ADDR: capture the address and go to DATA.
  - DATA: shift bytes into a 40-bit assembler. After the last byte go to WRITE.
  - WRITE: drive the target addr/init from the assembled value and hold the target `we` high for exactly `STRETCH` cycles, then go to HDR.
  - START (header 0xFF in HDR): next cycle `rst_switch`=0 and `start_switch`=1, then RUN.
  - RUN: terminal state. Input is ignored (`s_ready`=0) and only `rst` exits.
- Outputs after a write:
  - addr/init keep their last written value.
  - Only `*_we` returns to 0.
  - Non-target ports are never touched.
- Timeout: in ADDR or DATA, a counter clears on every accepted byte. When it reaches `IDLE_TIMEOUT`, the partial record is dropped, `err` is set, the FSM returns to HDR and no `we` is issued.
- Reset values:
  - All addr/init/we outputs = 0.
  - `rst_switch`=1, `start_switch`=0, `busy`=0, `err`=0, `s_ready`=0.
  - FSM in HDR.
- Reset mid-record or mid-WRITE: the record is abandoned and any `we` falls in the same cycle the reset is sampled.

## Timing
- Last data byte accepted at edge N: `*_we`=1 during cycles N+1 … N+STRETCH; `s_ready`=1 again from N+STRETCH+1.
- START header accepted at edge N: `rst_switch` falls and `start_switch` rises in cycle N+1.
- `s_valid` gaps anywhere inside a record are legal and add latency only.
- Minimum BTB record: 7 accepted bytes + `STRETCH` cycles.
- `err` is registered; it rises the cycle after the offending byte or timeout.
- Timeout counter width: clog2(IDLE_TIMEOUT+1).

## Structure
- Package `cpu_init_pkg` holds:
  - header constants `HDR_NOP`, `HDR_BTB`, `HDR_BHT`, `HDR_REG`, `HDR_START`;
  - the state enum (HDR, ADDR, DATA, WRITE, RUN);
  - per-target data byte counts (5/1/4);
  - port widths (BTB 40, BHT 2, REG 32, address 8/8/5).
- Sub-module `init_byte_assembler`: 40-bit shift register with load/shift controls and a remaining-byte counter, reporting `last_byte`.
- The FSM, stretch counter and timeout counter stay in the top.

## Test plan
- BTB write: bytes 01 12 AA BB CC DD EE → `btb_addr`=0x12, `btb_init`=0xAABBCCDDEE, `btb_we` high for exactly 2 cycles, `s_ready` low during those cycles, other `we` stay 0.
- REG write with masking and gaps: 03 25 DE AD BE EF, with `s_valid` low 3 cycles between each byte → `reg_addr`=5, `reg_init`=0xDEADBEEF, one 2-cycle `reg_we`.
- Error recovery: 7E then 02 07 03 → `err`=1 the cycle after 7E. `bht_addr`=0x07, `bht_init`=2'b11 and `bht_we` pulses anyway; `err` stays 1.
- Timeout (`IDLE_TIMEOUT`=16): 01 12 AA then idle for 16 cycles → `err`=1, FSM in HDR, no `btb_we`. A following 00 NOP is accepted.
- Start: FF → next cycle `rst_switch`=0, `start_switch`=1, `s_ready`=0. Further bytes produce no `we`. Asserting `rst` restores `rst_switch`=1, `start_switch`=0.
- Reset mid-WRITE: assert `rst` in the first `we` cycle → `btb_we`=0 the next cycle and all outputs at reset values.

Source files
------------

// File: rtl/cpu_init_pkg.sv
// cpu_init_pkg
// Shared definitions for the CPU table-initialisation loader: record header
// codes, FSM state and write-target enums, per-target data byte counts and
// the widths of the BTB, BHT and register-file init ports.
package cpu_init_pkg;

    // Record header codes seen as the first byte of every record
    localparam logic [7:0] HDR_NOP   = 8'h00;
    localparam logic [7:0] HDR_BTB   = 8'h01;
    localparam logic [7:0] HDR_BHT   = 8'h02;
    localparam logic [7:0] HDR_REG   = 8'h03;
    localparam logic [7:0] HDR_START = 8'hFF;

    // Number of data bytes following the address byte, per target
    localparam int BTB_BYTES = 5;
    localparam int BHT_BYTES = 1;
    localparam int REG_BYTES = 4;

    // Init port widths
    localparam int BTB_W  = 40;
    localparam int BHT_W  = 2;
    localparam int REG_W  = 32;
    localparam int BTB_AW = 8;
    localparam int BHT_AW = 8;
    localparam int REG_AW = 5;

    // Assembler holds the widest payload; byte counter covers up to 5
    localparam int ASM_W = 40;
    localparam int CNT_W = 3;

    typedef enum logic [2:0] {HDR, ADDR, DATA, WRITE, RUN} state_t;

    typedef enum logic [1:0] {TGT_BTB, TGT_BHT, TGT_REG} target_t;

    function automatic logic [CNT_W-1:0] data_bytes(input target_t t);
        case (t)
            TGT_BTB: data_bytes = CNT_W'(BTB_BYTES);
            TGT_BHT: data_bytes = CNT_W'(BHT_BYTES);
            default: data_bytes = CNT_W'(REG_BYTES);
        endcase
    endfunction

endpackage

// File: rtl/init_byte_assembler.sv
// init_byte_assembler
// 40-bit big-endian byte assembler. A load clears the shift register and
// arms a remaining-byte counter; each shift pushes one byte in at the LSB.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   load            clear the register and start a new payload
//   load_count      number of payload bytes expected after load
//   shift           accept byte_in into the register
//   byte_in         incoming payload byte
//   next_data       register contents as they will be after shifting byte_in;
//                   lets the caller latch the finished word on the last byte
//   last_byte       the byte currently presented is the final one
module init_byte_assembler
    import cpu_init_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             shift,
    input  logic [7:0]       byte_in,
    output logic [ASM_W-1:0] next_data,
    output logic             last_byte
);

    logic [ASM_W-1:0] data;
    logic [CNT_W-1:0] remaining;

    assign next_data = {data[ASM_W-9:0], byte_in};
    assign last_byte = (remaining == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            remaining <= '0;
        end else if (load) begin
            data      <= '0;
            remaining <= load_count;
        end else if (shift && remaining != '0) begin
            data      <= next_data;
            remaining <= remaining - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_init_loader.sv
// cpu_init_loader
// Boot-time loader: parses a valid/ready byte stream into BTB, BHT and
// register-file init writes, then releases the CPU on a START record.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   s_valid, s_data, s_ready   input byte stream handshake
//   btb_addr/btb_init/btb_we   BTB init port
//   bht_addr/bht_init/bht_we   BHT init port
//   reg_addr/reg_init/reg_we   register-file init port
//   rst_switch, start_switch   CPU hold / release controls
//   busy                       a record is in progress
//   err                        sticky error (bad header or idle timeout)
module cpu_init_loader
    import cpu_init_pkg::*;
#(
    parameter int STRETCH      = 2,
    parameter int IDLE_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [BTB_AW-1:0] btb_addr,
    output logic [BTB_W-1:0]  btb_init,
    output logic              btb_we,
    output logic [BHT_AW-1:0] bht_addr,
    output logic [BHT_W-1:0]  bht_init,
    output logic              bht_we,
    output logic [REG_AW-1:0] reg_addr,
    output logic [REG_W-1:0]  reg_init,
    output logic              reg_we,
    output logic              rst_switch,
    output logic              start_switch,
    output logic              busy,
    output logic              err
);

    localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int ST_W = $clog2(STRETCH + 1);

    state_t           state;
    target_t          target;
    logic [7:0]       addr_q;
    logic [TO_W-1:0]  idle_cnt;
    logic [ST_W-1:0]  stretch_cnt;

    logic             take;
    logic             asm_load;
    logic [CNT_W-1:0] asm_count;
    logic             asm_shift;
    logic [ASM_W-1:0] asm_next;
    logic             asm_last;
    logic             timed_out;

    // Ready depends on rst directly so no byte is taken during reset
    assign s_ready   = !rst && (state == HDR || state == ADDR || state == DATA);
    assign take      = s_valid && s_ready;
    assign asm_shift = (state == DATA) && take;
    assign timed_out = !take && (idle_cnt == TO_W'(IDLE_TIMEOUT - 1));

    // Arm the assembler with the payload length as a data-bearing header is taken
    always_comb begin
        asm_load  = 1'b0;
        asm_count = '0;
        if (state == HDR && take) begin
            case (s_data)
                HDR_BTB: begin asm_load = 1'b1; asm_count = data_bytes(TGT_BTB); end
                HDR_BHT: begin asm_load = 1'b1; asm_count = data_bytes(TGT_BHT); end
                HDR_REG: begin asm_load = 1'b1; asm_count = data_bytes(TGT_REG); end
                default: ;
            endcase
        end
    end

    init_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .load       (asm_load),
        .load_count (asm_count),
        .shift      (asm_shift),
        .byte_in    (s_data),
        .next_data  (asm_next),
        .last_byte  (asm_last)
    );

    // Record FSM. The target port is written on the same edge that takes the
    // last data byte (using the assembler's look-ahead word), so we is high for
    // exactly STRETCH cycles starting the cycle after that byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HDR;
            target       <= TGT_BTB;
            addr_q       <= '0;
            idle_cnt     <= '0;
            stretch_cnt  <= '0;
            btb_addr     <= '0;
            btb_init     <= '0;
            btb_we       <= 1'b0;
            bht_addr     <= '0;
            bht_init     <= '0;
            bht_we       <= 1'b0;
            reg_addr     <= '0;
            reg_init     <= '0;
            reg_we       <= 1'b0;
            rst_switch   <= 1'b1;
            start_switch <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                HDR: begin
                    idle_cnt <= '0;
                    if (take) begin
                        case (s_data)
                            HDR_NOP: ;
                            HDR_BTB: begin target <= TGT_BTB; state <= ADDR; busy <= 1'b1; end
                            HDR_BHT: begin target <= TGT_BHT; state <= ADDR; busy <= 1'b1; end
                            HDR_REG: begin target <= TGT_REG; state <= ADDR; busy <= 1'b1; end
                            HDR_START: begin
                                state        <= RUN;
                                rst_switch   <= 1'b0;
                                start_switch <= 1'b1;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                ADDR, DATA: begin
                    if (take) begin
                        idle_cnt <= '0;
                        if (state == ADDR) begin
                            addr_q <= s_data;
                            state  <= DATA;
                        end else if (asm_last) begin
                            state       <= WRITE;
                            stretch_cnt <= '0;
                            case (target)
                                TGT_BTB: begin
                                    btb_addr <= addr_q[BTB_AW-1:0];
                                    btb_init <= asm_next[BTB_W-1:0];
                                    btb_we   <= 1'b1;
                                end
                                TGT_BHT: begin
                                    bht_addr <= addr_q[BHT_AW-1:0];
                                    bht_init <= asm_next[BHT_W-1:0];
                                    bht_we   <= 1'b1;
                                end
                                default: begin
                                    reg_addr <= addr_q[REG_AW-1:0];
                                    reg_init <= asm_next[REG_W-1:0];
                                    reg_we   <= 1'b1;
                                end
                            endcase
                        end
                    end else if (timed_out) begin
                        // Abandon the partial record without any write
                        state    <= HDR;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
                WRITE: begin
                    if (stretch_cnt == ST_W'(STRETCH - 1)) begin
                        btb_we <= 1'b0;
                        bht_we <= 1'b0;
                        reg_we <= 1'b0;
                        busy   <= 1'b0;
                        state  <= HDR;
                    end else begin
                        stretch_cnt <= stretch_cnt + ST_W'(1);
                    end
                end
                RUN: ;
                default: state <= HDR;
            endcase
        end
    end

endmodule
